// File: rtl/avalon_burst_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// avalon_burst_slave_arbiter_if
// Bus bundle between NUM_MASTERS packed Avalon-MM burst master ports and one
// Avalon-MM slave port, as seen by one crossbar output arbiter.
//
// Handshake: a transfer (one beat) completes on a rising clock edge where
// read or write is high and waitrequest is low. While waitrequest is high the
// requester holds address, byteenable, writedata and burstcount stable.
//
// Signals (names keep the crossbar's i_/o_ convention from the arbiter's view):
//   i_AVIn_*   packed master-side inputs, master 0 in the LSBs
//   o_AVIn_*   packed master-side returns (read data, waitrequest)
//   o_AVOut_*  slave-side request signals
//   i_AVOut_*  slave-side returns
// Modports:
//   slave  - the arbiter's view
//   master - the environment driving masters and modelling the slave
// ---------------------------------------------------------------------------
interface avalon_burst_slave_arbiter_if #(
  parameter int NUM_MASTERS = 5,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 8
);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     i_AVIn_Addr;
  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] i_AVIn_ByteEn;
  logic [NUM_MASTERS-1:0]                i_AVIn_Read;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]     o_AVIn_ReadData;
  logic [NUM_MASTERS-1:0]                i_AVIn_Write;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]     i_AVIn_WriteData;
  logic [NUM_MASTERS-1:0]                o_AVIn_WaitRequest;
  logic [NUM_MASTERS*BURST_WIDTH-1:0]    i_AVIn_BurstCount;

  logic [ADDR_WIDTH-1:0]                 o_AVOut_Addr;
  logic [DATA_WIDTH/8-1:0]               o_AVOut_ByteEn;
  logic                                  o_AVOut_Read;
  logic [DATA_WIDTH-1:0]                 i_AVOut_ReadData;
  logic                                  o_AVOut_Write;
  logic [DATA_WIDTH-1:0]                 o_AVOut_WriteData;
  logic                                  i_AVOut_WaitRequest;
  logic [BURST_WIDTH-1:0]                o_AVOut_BurstCount;

  modport slave (
    input  i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
           i_AVIn_WriteData, i_AVIn_BurstCount, i_AVOut_ReadData,
           i_AVOut_WaitRequest,
    output o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVOut_Addr, o_AVOut_ByteEn,
           o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData, o_AVOut_BurstCount
  );

  modport master (
    output i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
           i_AVIn_WriteData, i_AVIn_BurstCount, i_AVOut_ReadData,
           i_AVOut_WaitRequest,
    input  o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVOut_Addr, o_AVOut_ByteEn,
           o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData, o_AVOut_BurstCount
  );
endinterface

// File: rtl/avalon_burst_slave_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_burst_slave_arbiter
// Per-slave-port arbiter of the Avalon burst crossbar. Masters whose address
// MSBs decode to ADDR_SEL request this slave; a round-robin search picks one,
// the grant is locked for the whole burst, and the winner is muxed onto the
// slave port. At least one IDLE cycle separates consecutive bursts.
//
// Ports:
//   i_Clk, i_Reset  clock, synchronous active-high reset
//   av              bus bundle (slave modport), see the interface file
//   o_Grant         one-hot current grant, 0 when idle
//   o_Busy          burst in progress
//   o_dbg_state     FSM state (0 = IDLE, 1 = BURST)
// ---------------------------------------------------------------------------
module avalon_burst_slave_arbiter #(
  parameter int NUM_MASTERS   = 5,
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_WIDTH   = 8,
  parameter int ADDR_SEL_BITS = 5,
  parameter int ADDR_SEL      = 0
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  avalon_burst_slave_arbiter_if.slave av,
  output logic [NUM_MASTERS-1:0]      o_Grant,
  output logic                        o_Busy,
  output logic                        o_dbg_state
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [ADDR_SEL_BITS-1:0] SEL_VAL = ADDR_SEL_BITS'(ADDR_SEL);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;    // highest-priority master
  logic [PTR_W-1:0]       gidx_q, gidx_d;  // index of the granted master
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;    // beats still owed in this burst

  logic [NUM_MASTERS-1:0] req;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [BURST_WIDTH-1:0] win_bc;
  int                     rr_idx;
  logic                   beat;

  // Request decode: strobe plus address-MSB match.
  always_comb begin
    req = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      req[m] = (av.i_AVIn_Read[m] | av.i_AVIn_Write[m]) &&
               (av.i_AVIn_Addr[m*ADDR_WIDTH + ADDR_WIDTH-1 -: ADDR_SEL_BITS] == SEL_VAL);
    end
  end

  // Round-robin search upward from the pointer, wrapping at NUM_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_idx = (int'(ptr_q) + i) % NUM_MASTERS;
      if (!win_found && req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(rr_idx);
      end
    end
    win_bc = av.i_AVIn_BurstCount[int'(win_idx)*BURST_WIDTH +: BURST_WIDTH];
  end

  // Slave-side mux and master-side returns. Only the granted master ever
  // sees the slave's waitrequest and read data.
  always_comb begin
    av.o_AVOut_Addr       = '0;
    av.o_AVOut_ByteEn     = '0;
    av.o_AVOut_Read       = 1'b0;
    av.o_AVOut_Write      = 1'b0;
    av.o_AVOut_WriteData  = '0;
    av.o_AVOut_BurstCount = '0;
    av.o_AVIn_WaitRequest = '1;
    av.o_AVIn_ReadData    = '0;
    if (state_q == S_BURST) begin
      av.o_AVOut_Addr       = av.i_AVIn_Addr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      av.o_AVOut_ByteEn     = av.i_AVIn_ByteEn[int'(gidx_q)*BE_W +: BE_W];
      av.o_AVOut_Read       = av.i_AVIn_Read[gidx_q];
      av.o_AVOut_Write      = av.i_AVIn_Write[gidx_q];
      av.o_AVOut_WriteData  = av.i_AVIn_WriteData[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
      av.o_AVOut_BurstCount = av.i_AVIn_BurstCount[int'(gidx_q)*BURST_WIDTH +: BURST_WIDTH];
      av.o_AVIn_WaitRequest[gidx_q] = av.i_AVOut_WaitRequest;
      av.o_AVIn_ReadData[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] = av.i_AVOut_ReadData;
    end
  end

  // A granted master dropping its strobe mid-burst simply produces no beat,
  // so the counter and the grant are held until the owed beats arrive.
  assign beat = (av.o_AVOut_Read | av.o_AVOut_Write) & ~av.i_AVOut_WaitRequest;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_BURST;
          grant_d = NUM_MASTERS'(1) << win_idx;
          gidx_d  = win_idx;
          cnt_d   = (win_bc == '0) ? BURST_WIDTH'(1) : win_bc;  // 0 means 1 beat
        end
      end
      S_BURST: begin
        if (beat) begin
          if (cnt_q == BURST_WIDTH'(1)) begin
            state_d = S_IDLE;
            grant_d = '0;
            cnt_d   = '0;
            ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Grant     = grant_q;
  assign o_Busy      = (state_q == S_BURST);
  assign o_dbg_state = (state_q == S_BURST);

endmodule

// File: tb/tb_avalon_burst_slave_arbiter.sv
module tb_avalon_burst_slave_arbiter;
  localparam int NM  = 5;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int BE  = DW / 8;
  localparam int SB  = 5;
  localparam int SEL = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avalon_burst_slave_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  logic [NM-1:0] grant;
  logic          busy;
  logic          dbg;

  avalon_burst_slave_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BURST_WIDTH(BW), .ADDR_SEL_BITS(SB), .ADDR_SEL(SEL)) dut (
    .i_Clk(clk), .i_Reset(rst), .av(bus), .o_Grant(grant), .o_Busy(busy),
    .o_dbg_state(dbg));

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Whole-burst view: who owns the slave, how many beats are still owed,
  // and which master is next in line.
  bit m_busy;
  int m_win, m_rem, m_ptr;

  function automatic bit m_req(int m);
    logic [AW-1:0] a;
    a = bus.i_AVIn_Addr[m*AW +: AW];
    return (bus.i_AVIn_Read[m] | bus.i_AVIn_Write[m]) && (int'(a >> (AW - SB)) == SEL);
  endfunction

  function automatic int m_bc(int m);
    int b;
    b = int'(bus.i_AVIn_BurstCount[m*BW +: BW]);
    return (b == 0) ? 1 : b;
  endfunction

  function automatic logic [NM-1:0] exp_grant();
    return m_busy ? (NM'(1) << m_win) : '0;
  endfunction

  task automatic model_step();
    int c;
    if (rst) begin
      m_busy = 0; m_win = 0; m_rem = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NM; k++) begin
        c = (m_ptr + k) % NM;
        if (m_req(c)) begin
          m_busy = 1; m_win = c; m_rem = m_bc(c);
          break;
        end
      end
    end else if ((bus.i_AVIn_Read[m_win] | bus.i_AVIn_Write[m_win]) && !bus.i_AVOut_WaitRequest) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 0;
        m_ptr  = (m_win + 1) % NM;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_master(int m, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d,
                            logic [BW-1:0] bc, logic [BE-1:0] be);
    bus.i_AVIn_Read[m]              = rd;
    bus.i_AVIn_Write[m]             = wr;
    bus.i_AVIn_Addr[m*AW +: AW]     = a;
    bus.i_AVIn_WriteData[m*DW +: DW] = d;
    bus.i_AVIn_BurstCount[m*BW +: BW] = bc;
    bus.i_AVIn_ByteEn[m*BE +: BE]   = be;
  endtask

  task automatic clear_all();
    bus.i_AVIn_Addr         = '0;
    bus.i_AVIn_ByteEn       = '0;
    bus.i_AVIn_Read         = '0;
    bus.i_AVIn_Write        = '0;
    bus.i_AVIn_WriteData    = '0;
    bus.i_AVIn_BurstCount   = '0;
    bus.i_AVOut_ReadData    = '0;
    bus.i_AVOut_WaitRequest = 1'b0;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_all();
    set_master(0, 0, 1, '0, 32'h11, 8'd4, 4'hF);
    bus.i_AVOut_ReadData = 32'hDEADBEEF;
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want %b", grant, 5'b0); end
    n_vec++; if (busy !== 1'b0 || dbg !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, dbg); end
    n_vec++; if (bus.o_AVOut_Read !== 1'b0 || bus.o_AVOut_Write !== 1'b0) begin n_err++;
      $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.o_AVOut_Read, bus.o_AVOut_Write); end
    n_vec++; if (bus.o_AVIn_WaitRequest !== '1) begin n_err++;
      $display("FAIL reset_waitreq: got %b want 11111", bus.o_AVIn_WaitRequest); end
    n_vec++; if (bus.o_AVIn_ReadData !== '0) begin n_err++;
      $display("FAIL reset_readdata: got %h want 0", bus.o_AVIn_ReadData); end
    rst = 1'b0;
    clear_all();
  endtask

  task automatic test_single_write();
    bit phase;
    int beats;
    do_reset();
    set_master(0, 0, 1, '0, 32'd1, 8'd4, 4'hF);
    bus.i_AVOut_WaitRequest = 1'b1;
    #1;
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL sw_req_cycle: got %b want 00000", grant); end
    tick();
    #1;
    n_vec++; if (grant !== 5'b00001) begin n_err++; $display("FAIL sw_grant_latency: got %b want 00001", grant); end
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    beats = 0;
    phase = 1'b1;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      bus.i_AVOut_WaitRequest = phase;
      bus.i_AVIn_WriteData[0 +: DW] = DW'(beats + 1);
      #1;
      n_vec++; if (grant !== exp_grant()) begin n_err++; $display("FAIL sw_grant: got %b want %b", grant, exp_grant()); end
      if (bus.o_AVOut_Write && !bus.i_AVOut_WaitRequest) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL sw_extra_beat: got %h want none", bus.o_AVOut_WriteData); end
        else begin
          if (bus.o_AVOut_WriteData !== exp_q[0]) begin n_err++;
            $display("FAIL sw_wdata: got %h want %h", bus.o_AVOut_WriteData, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        beats++;
      end
      phase = ~phase;
      tick();
    end
    set_master(0, 0, 0, '0, '0, '0, '0);
    #1;
    n_vec++; if (beats != 4 || exp_q.size() != 0) begin n_err++; $display("FAIL sw_beats: got %0d want 4", beats); end
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL sw_release: got %b want 00000", grant); end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] eg;
    do_reset();
    set_master(0, 0, 1, '0, 32'hA0, 8'd1, 4'hF);
    set_master(1, 0, 1, '0, 32'hA1, 8'd1, 4'hF);
    for (int c = 0; c < 9; c++) begin
      eg = (c % 2 == 0) ? 5'b00000 : (((c / 2) % 2 == 0) ? 5'b00001 : 5'b00010);
      #1;
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL rr_grant c%0d: got %b want %b", c, grant, eg); end
      for (int m = 0; m < 2; m++) begin
        n_vec++; if (bus.o_AVIn_WaitRequest[m] !== !eg[m]) begin n_err++;
          $display("FAIL rr_waitreq c%0d m%0d: got %b want %b", c, m, bus.o_AVIn_WaitRequest[m], !eg[m]); end
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_mid_burst_gap();
    logic [NM-1:0] eg;
    do_reset();
    set_master(1, 0, 1, '0, 32'd99, 8'd1, 4'hF);
    for (int c = 0; c < 12; c++) begin
      set_master(0, 0, (c <= 8) && !(c >= 3 && c <= 6), '0, DW'(c), 8'd4, 4'hF);
      eg = (c == 0 || c == 9 || c == 11) ? 5'b00000 : ((c == 10) ? 5'b00010 : 5'b00001);
      #1;
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL gap_grant c%0d: got %b want %b", c, grant, eg); end
      if (c >= 3 && c <= 6) begin
        n_vec++; if (bus.o_AVOut_Write !== 1'b0 || bus.o_AVIn_WaitRequest[1] !== 1'b1) begin n_err++;
          $display("FAIL gap_hold c%0d: got wr=%b wait1=%b want 0 1", c, bus.o_AVOut_Write, bus.o_AVIn_WaitRequest[1]); end
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_decode_filter();
    do_reset();
    set_master(1, 0, 1, 30'h4000000, 32'h5, 8'd1, 4'hF);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++; if (grant !== '0 || bus.o_AVOut_Write !== 1'b0 || bus.o_AVIn_WaitRequest[1] !== 1'b1) begin n_err++;
        $display("FAIL decode c%0d: got grant=%b wr=%b wait1=%b want 00000 0 1", c, grant,
                 bus.o_AVOut_Write, bus.o_AVIn_WaitRequest[1]); end
      tick();
    end
    clear_all();
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] rd;
    do_reset();
    rd = DW'($urandom);
    set_master(0, 1, 0, '0, '0, 8'd4, 4'hF);
    bus.i_AVOut_ReadData = rd;
    #1;
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL rmb_req: got %b want 00000", grant); end
    tick();
    #1;
    n_vec++; if (grant !== 5'b00001) begin n_err++; $display("FAIL rmb_grant: got %b want 00001", grant); end
    n_vec++; if (bus.o_AVIn_ReadData[0 +: DW] !== rd || bus.o_AVIn_ReadData[DW +: (NM-1)*DW] !== '0) begin n_err++;
      $display("FAIL rmb_rdata: got %h want %h in lane 0 only", bus.o_AVIn_ReadData, rd); end
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (grant !== 5'b00001 || bus.o_AVOut_Read !== 1'b1) begin n_err++;
      $display("FAIL rmb_beat2: got grant=%b rd=%b want 00001 1", grant, bus.o_AVOut_Read); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (grant !== '0 || bus.o_AVOut_Read !== 1'b0 || bus.o_AVIn_WaitRequest !== '1) begin n_err++;
      $display("FAIL rmb_after: got grant=%b rd=%b wait=%b want 00000 0 11111", grant,
               bus.o_AVOut_Read, bus.o_AVIn_WaitRequest); end
    tick();
    #1;
    n_vec++; if (grant !== 5'b00001) begin n_err++; $display("FAIL rmb_regrant: got %b want 00001", grant); end
    clear_all();
  endtask

  task automatic test_burstcount_zero();
    do_reset();
    set_master(2, 0, 1, '0, 32'h7, 8'd0, 4'hF);
    bus.i_AVOut_WaitRequest = 1'b1;
    #1;
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL bc0_req: got %b want 00000", grant); end
    tick();
    #1;
    n_vec++; if (grant !== 5'b00100) begin n_err++; $display("FAIL bc0_grant: got %b want 00100", grant); end
    tick();
    bus.i_AVOut_WaitRequest = 1'b0;
    #1;
    n_vec++; if (grant !== 5'b00100 || bus.o_AVOut_Write !== 1'b1) begin n_err++;
      $display("FAIL bc0_beat: got grant=%b wr=%b want 00100 1", grant, bus.o_AVOut_Write); end
    tick();
    set_master(2, 0, 0, '0, '0, '0, '0);
    #1;
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL bc0_release: got %b want 00000", grant); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int op;
    logic [NM-1:0] eg;
    bit ew;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < NM; m++) begin
        op = $urandom_range(0, 3);
        a = AW'($urandom);
        a[AW-1 -: SB] = ($urandom_range(0, 4) == 0) ? SB'($urandom_range(1, 31)) : SB'(SEL);
        set_master(m, op == 1, op == 2, a, DW'($urandom), BW'($urandom_range(0, 3)), BE'($urandom));
      end
      bus.i_AVOut_WaitRequest = ($urandom_range(0, 2) == 0);
      bus.i_AVOut_ReadData    = DW'($urandom);
      #1;
      eg = exp_grant();
      n_vec++; if (grant !== eg || busy !== m_busy) begin n_err++;
        $display("FAIL rnd_grant c%0d: got %b/%b want %b/%b", c, grant, busy, eg, m_busy); end
      n_vec++;
      if (bus.o_AVOut_Read !== (m_busy && bus.i_AVIn_Read[m_win]) ||
          bus.o_AVOut_Write !== (m_busy && bus.i_AVIn_Write[m_win])) begin n_err++;
        $display("FAIL rnd_strobe c%0d: got rd=%b wr=%b busy=%b", c, bus.o_AVOut_Read, bus.o_AVOut_Write, m_busy); end
      if (m_busy) begin
        n_vec++;
        if (bus.o_AVOut_Addr !== bus.i_AVIn_Addr[m_win*AW +: AW] ||
            bus.o_AVOut_ByteEn !== bus.i_AVIn_ByteEn[m_win*BE +: BE] ||
            bus.o_AVOut_WriteData !== bus.i_AVIn_WriteData[m_win*DW +: DW] ||
            bus.o_AVOut_BurstCount !== bus.i_AVIn_BurstCount[m_win*BW +: BW]) begin n_err++;
          $display("FAIL rnd_mux c%0d: got addr=%h be=%h wd=%h bc=%h from master %0d", c, bus.o_AVOut_Addr,
                   bus.o_AVOut_ByteEn, bus.o_AVOut_WriteData, bus.o_AVOut_BurstCount, m_win); end
      end
      for (int m = 0; m < NM; m++) begin
        ew = (m_busy && m == m_win) ? bus.i_AVOut_WaitRequest : 1'b1;
        n_vec++;
        if (bus.o_AVIn_WaitRequest[m] !== ew ||
            bus.o_AVIn_ReadData[m*DW +: DW] !== ((m_busy && m == m_win) ? bus.i_AVOut_ReadData : '0)) begin n_err++;
          $display("FAIL rnd_return c%0d m%0d: got wait=%b rdata=%h want wait=%b", c, m,
                   bus.o_AVIn_WaitRequest[m], bus.o_AVIn_ReadData[m*DW +: DW], ew); end
      end
      tick();
    end
    rst = 1'b0;
    clear_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_all();
    m_busy = 0; m_win = 0; m_rem = 0; m_ptr = 0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_mid_burst_gap();
    test_decode_filter();
    test_reset_mid_burst();
    test_burstcount_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
